timetag_sampler: RTL
====================

TIMETAG_SAMPLER -- requirements
Module: timetag_sampler

Interface
REQ-001 Parameter: FIFO_ABITS, default 3, log2 of record FIFO depth (depth = 2**FIFO_ABITS = 8).
REQ-002 Parameter: TS_WIDTH, default 36, timestamp counter width; SHALL be fixed at 36 for the 48-bit record format.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: capture_en  input  1  high = timestamp counter runs and strobes are recorded.
REQ-006 Port: strobe_in  input  4  per-channel detector strobes, asynchronous to clk.
REQ-007 Port: sample  output  48  head-of-FIFO record, valid while sample_rdy high.
REQ-008 Port: sample_rdy  output  1  high while FIFO is non-empty.
REQ-009 Port: sample_ack  input  1  single-cycle pulse from the downstream byte serializer; pops the head record.
REQ-010 Port: lost_count  output  16  saturating count of records dropped because the FIFO was full.

Function
REQ-011 Each strobe_in bit SHALL pass through a 2-flop synchronizer, then rising-edge detection against a third flop.
REQ-012 Counter ts (36 bit) SHALL increment by 1 each cycle while capture_en = 1, hold while capture_en = 0, and wrap from 36'hF_FFFF_FFFF to 0.
REQ-013 Record layout: [47] wrap, [46] lost, [45:42] channel mask, [41:36] zero, [35:0] timestamp.
REQ-014 Strobe event: in a cycle with capture_en = 1 and any detected rising edge, one record SHALL be built with channel mask = detected-edge vector and timestamp = current ts value (pre-increment).
REQ-015 Wrap event: in the cycle where ts holds all-ones and capture_en = 1, one record SHALL be built with wrap = 1 and timestamp = all-ones.
REQ-016 Strobe and wrap in the same cycle SHALL merge into one record: wrap = 1, mask = edges, timestamp = all-ones.
REQ-017 At most one record SHALL be pushed per cycle; edges detected while capture_en = 0 SHALL be discarded.
REQ-018 Latency: a strobe_in bit first sampled high at edge N SHALL produce a push at edge N+3; with the FIFO empty, sample_rdy SHALL go high after edge N+3.
REQ-019 FIFO: synchronous, depth 2**FIFO_ABITS, first-in first-out, with a registered occupancy count of FIFO_ABITS+1 bits.
REQ-020 sample SHALL be the head entry and SHALL stay stable from sample_rdy rise until the sample_ack pop.
REQ-021 sample_ack with sample_rdy = 1 SHALL pop exactly one record; sample_ack with sample_rdy = 0 SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged, including when the FIFO is full.
REQ-023 Push while full with no pop SHALL drop the record, set the internal lost_pending flag, and increment lost_count, saturating at 16'hFFFF.
REQ-024 The next successfully pushed record SHALL carry lost = 1, and lost_pending SHALL clear in that same cycle.
REQ-025 Pointers SHALL wrap modulo depth; the full and empty indications SHALL derive from the occupancy count.

Reset
REQ-026 While reset = 1 at a clk edge: ts = 0, FIFO empty, sample_rdy = 0, lost_count = 0, lost_pending = 0, synchronizer and edge flops = 0.
REQ-027 sample SHALL be 48'h0 after reset until the first push.
REQ-028 Reset mid-operation SHALL discard all buffered records and any in-flight edges; sample_ack during reset SHALL be ignored.
REQ-029 A strobe_in held high through reset release SHALL produce one edge after release, because the edge flops are cleared.

Verification
REQ-030 Test: reset, capture_en = 1, strobe_in = 4'b0001 pulse of 3 cycles rising at edge N -> one record at N+3: mask 0001, wrap 0, lost 0, timestamp = ts at detection; no second record.
REQ-031 Test: strobe_in rises on bits 0 and 2 at the same edge -> a single record with mask 0101.
REQ-032 Test: force ts to all-ones - 2 with a strobe aligned to the all-ones cycle -> one merged record: wrap 1, mask set, timestamp 36'hF_FFFF_FFFF; the next ts value is 0.
REQ-033 Test: sample_ack held low, 10 strobe events -> 8 records stored and lost_count = 2; drain all 8, then one more strobe -> its record has lost = 1, and the record after it has lost = 0.
REQ-034 Test: FIFO full, push and sample_ack in the same cycle -> occupancy stays 8, lost_count unchanged, and the new record appears at the tail in order.
REQ-035 Test: assert reset with 5 records queued -> sample_rdy = 0 and lost_count = 0 after one edge; sample_ack pulses during reset produce no effect.

Source files
------------

// File: rtl/timetag_sampler_if.sv
// timetag_sampler_if
//   Record hand-off between the time-tag sampler and the downstream
//   byte serializer.
//
//   sample      48  head-of-FIFO record, valid while sample_rdy is high
//   sample_rdy   1  record FIFO is non-empty
//   sample_ack   1  single-cycle pulse from the consumer; pops the head
//
//   master: sampler side (drives sample / sample_rdy)
//   slave : serializer side (drives sample_ack)
interface timetag_sampler_if;
    logic [47:0] sample;
    logic        sample_rdy;
    logic        sample_ack;

    modport master (output sample, output sample_rdy, input sample_ack);
    modport slave  (input sample, input sample_rdy, output sample_ack);
endinterface

// File: rtl/timetag_sampler.sv
// timetag_sampler
//   Time-tags rising edges on four asynchronous detector strobes against a
//   free-running 36-bit counter and queues 48-bit records in a small FIFO.
//   Counter wrap-around is also recorded so the consumer can extend time.
//
//   Record: [47] wrap, [46] lost, [45:42] channel mask, [41:36] zero,
//           [35:0] timestamp.
//
//   Ports
//     clk         sole clock, rising edge
//     reset       synchronous, active-high
//     capture_en  counter runs and strobes are recorded while high
//     strobe_in   4 detector strobes, asynchronous to clk
//     smp         record hand-off (sample / sample_rdy / sample_ack)
//     lost_count  saturating count of records dropped on a full FIFO
module timetag_sampler #(
    parameter int FIFO_ABITS = 3,
    parameter int TS_WIDTH   = 36
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic [3:0]               strobe_in,
    timetag_sampler_if.master        smp,
    output logic [15:0]              lost_count
);

    localparam int                DEPTH      = 1 << FIFO_ABITS;
    localparam logic [FIFO_ABITS:0] FULL_COUNT = (FIFO_ABITS + 1)'(DEPTH);

    // Strobe synchronizers, edge reference and registered edge vector.
    logic [3:0] sync1, sync2, sync3;
    logic [3:0] edge_r;

    logic [TS_WIDTH-1:0] ts, ts_next;

    logic [47:0]           mem [DEPTH];
    logic [FIFO_ABITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ABITS:0]   count;
    logic                  lost_pending;

    logic        ts_max, push_req, push_ok, drop, pop, empty, full;
    logic [47:0] record;

    assign ts_max   = &ts;
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop      = smp.sample_ack & ~empty;
    // Strobe edges and the wrap marker share one record per cycle.
    assign push_req = capture_en & ((|edge_r) | ts_max);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    // When wrap is set ts is all-ones, so the timestamp field needs no mux.
    assign record   = {capture_en & ts_max, lost_pending, edge_r,
                       {(42 - TS_WIDTH){1'b0}}, ts};

    always_comb begin
        // NOTE: the default assignment comes first so that no path through
        // the block leaves ts_next unassigned, which would infer a latch.
        ts_next = ts;
        if (capture_en) begin
            ts_next = ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, which the synchronizer chain relies on.
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            edge_r       <= '0;
            ts           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lost_pending <= 1'b0;
            lost_count   <= '0;
        end else begin
            sync1  <= strobe_in;
            sync2  <= sync1;
            sync3  <= sync2;
            // Registered so a strobe first sampled at edge N pushes at N+3.
            edge_r <= sync2 & ~sync3;

            ts <= ts_next;

            if (push_ok) begin
                wr_ptr       <= wr_ptr + 1'b1;
                lost_pending <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop) begin
                lost_pending <= 1'b1;
                if (lost_count != 16'hFFFF) begin
                    lost_count <= lost_count + 1'b1;
                end
            end
        end
    end

    // NOTE: record storage is deliberately not reset; the pointers and count
    // are, and sample is forced to zero while empty so stale entries never
    // reach the output.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= record;
        end
    end

    assign smp.sample_rdy = ~empty;
    assign smp.sample     = empty ? 48'h0 : mem[rd_ptr];

endmodule
